dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- MEM-stage responder for the data-memory control signals the decoder emits: MemWrite, MemRead and the 3-bit DMType.
- Accepts one load or store per transaction, drives a wait-stated word-wide data bus with byte enables, and sign- or zero-extends load data.
- Stalls the pipeline until the access completes.
- Reports misaligned accesses, illegal DMType and bus timeouts as faults; a faulting access never reaches the bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles without bus_gnt (in REQ) or without bus_rvalid (in WAIT_R) before a timeout fault. Range 1..65535.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_valid  in  1  access request from the MEM stage.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- DMType  in  3  access size and signedness (encoding below).
- mem_addr  in  ADDR_W  byte address from the ALU.
- mem_wdata  in  32  store data from rs2.
- mem_stall  out  1  pipeline freeze.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  32  extended load result, valid while mem_done=1.
- mem_fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal DMType.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_be  out  4  byte enables.
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 00.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- DMType encoding: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101-111 illegal.
- States: IDLE, REQ, WAIT_R, DONE, FAULT. Transitions:
  - IDLE -> start when mem_valid & (MemRead | MemWrite); MemWrite wins if both are set.
  - At start, capture DMType, addr, wdata, we and addr[1:0]. Later input changes are ignored until the next start.
  - IDLE -> FAULT if DMType is illegal (cause 11) or the access is misaligned (cause 01). Misaligned means word with addr[1:0]!=0, or half with addr[0]=1. Illegal DMType has priority.
  - IDLE -> REQ otherwise.
  - REQ: bus_req=1 and all bus_* outputs held stable. On bus_gnt, a store goes to DONE and a load goes to WAIT_R.
  - WAIT_R: on bus_rvalid, register the extended data and go to DONE.
  - DONE: mem_done=1 for one cycle, then IDLE. FAULT: mem_fault=1 for one cycle, then IDLE.
- Timeout counter:
  - Clears on every state entry and counts while in REQ or WAIT_R.
  - Reaching TIMEOUT_CYCLES without the awaited handshake goes to FAULT with cause 10, and bus_req drops in that same transition.
  - bus_gnt or bus_rvalid arriving in the same cycle as the terminal count wins; no fault is raised.
- mem_stall is combinational. It is 1 in IDLE on a start cycle and throughout REQ and WAIT_R. It is 0 in DONE, FAULT, and in IDLE with no start.
- bus_rvalid seen outside WAIT_R is ignored.
- Store lanes:
  - word: be=1111, wdata unchanged.
  - half: be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - byte: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
- Loads: bus_we=0 and be=1111. The byte or half lane is selected by the captured addr[1:0], then sign- or zero-extended to 32 bits per DMType.
- Latency with zero wait states (gnt in the first REQ cycle, rvalid in the cycle after gnt):
  - store: 3 cycles from start to mem_done.
  - load: 4 cycles from start to mem_done.
- Reset values: state IDLE; all outputs 0 (bus_req, bus_we, bus_be, bus_addr, bus_wdata, mem_rdata, mem_done, mem_fault, fault_cause, mem_stall=0).
- Reset mid-transaction: bus_req falls asynchronously, the transaction is abandoned, and no done or fault pulse is produced.

Decomposition:
- Shared package holds:
  - DMType constants (dm_word, dm_halfword, dm_halfword_unsigned, dm_byte, dm_byte_unsigned);
  - fault-cause constants;
  - FSM state encoding.
- Sub-module dmem_lane_align: combinational store-lane replication and byte enables, plus load lane select and extension, driven by DMType and addr[1:0].
- The FSM and timeout counter stay in the top module.

Test Plan:
- Store byte: DMType=011, addr=0x1003, wdata=0x000000A5, gnt after 2 wait cycles -> bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5, we=1; mem_done 1 cycle after the gnt cycle; mem_stall high from the start cycle through REQ.
- Load half signed vs unsigned: addr=0x2002, bus_rdata=0x8001_1234 -> DMType=001 gives mem_rdata=0xFFFF8001; DMType=010 gives 0x00008001.
- Misaligned word load: addr=0x3001, DMType=000 -> FAULT next cycle with fault_cause=01; bus_req never asserted.
- Illegal DMType=110 with addr=0x3001 -> fault_cause=11 (takes priority over misaligned).
- Timeout: TIMEOUT_CYCLES=4, bus_gnt held 0 -> bus_req high for exactly 4 cycles, then mem_fault with fault_cause=10. Rerun with gnt in the 4th cycle -> no fault.
- Reset mid-operation: assert rstn=0 during WAIT_R -> bus_req=0 and mem_stall=0 immediately, no mem_done pulse. After release, a back-to-back word store then word load to 0x4000 both complete normally.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: DMType codes,
// fault causes, FSM states and the size/alignment helpers.
package dmem_access_unit_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  function automatic logic dm_legal(input logic [2:0] dm);
    return dm <= dm_byte_unsigned;
  endfunction

  // Bytes never misalign; halves need an even address, words a multiple of 4.
  function automatic logic dm_misaligned(input logic [2:0] dm, input logic [1:0] off);
    case (dm)
      dm_word:                           return off != 2'b00;
      dm_halfword, dm_halfword_unsigned: return off[0];
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data replication and byte enables, and
// load lane select with sign/zero extension, keyed by DMType and addr[1:0].
module dmem_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]  dmtype_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    case (off_i)
      2'b00:   byte_lane = ld_raw_i[7:0];
      2'b01:   byte_lane = ld_raw_i[15:8];
      2'b10:   byte_lane = ld_raw_i[23:16];
      default: byte_lane = ld_raw_i[31:24];
    endcase
  end

  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = ld_raw_i;
    case (dmtype_i)
      dm_halfword, dm_halfword_unsigned: begin
        st_be_o   = off_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = (dmtype_i == dm_halfword) ? {{16{half_lane[15]}}, half_lane}
                                              : {16'h0000, half_lane};
      end
      dm_byte, dm_byte_unsigned: begin
        st_be_o   = 4'b0001 << off_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = (dmtype_i == dm_byte) ? {{24{byte_lane[7]}}, byte_lane}
                                          : {24'h000000, byte_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store responder: one access per transaction over a
// wait-stated word bus, with alignment/DMType checks and a handshake timeout.
//
//   state    | meaning
//   ST_IDLE  | waiting for a start; checks DMType and alignment on start
//   ST_REQ   | bus_req high with stable bus fields, waiting for bus_gnt
//   ST_WAIT_R| load granted, waiting for bus_rvalid
//   ST_DONE  | one-cycle mem_done pulse
//   ST_FAULT | one-cycle mem_fault pulse with fault_cause
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_valid,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        DMType,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_fault,
  output logic [1:0]        fault_cause,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  dmtype_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [15:0] tmr_q;

  logic        start;
  logic        tmr_tc;
  logic [2:0]  la_dmtype;
  logic [1:0]  la_off;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign start  = mem_valid & (MemRead | MemWrite);
  assign tmr_tc = (tmr_q == 16'd0);

  // Store lanes come from the live inputs at start; load lanes from the capture.
  assign la_dmtype = (state_q == ST_IDLE) ? DMType : dmtype_q;
  assign la_off    = (state_q == ST_IDLE) ? mem_addr[1:0] : off_q;

  assign mem_stall = rstn & (((state_q == ST_IDLE) & start) |
                             (state_q == ST_REQ) | (state_q == ST_WAIT_R));

  dmem_lane_align u_lane_align (
    .dmtype_i  (la_dmtype),
    .off_i     (la_off),
    .st_data_i (mem_wdata),
    .ld_raw_i  (bus_rdata),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      dmtype_q    <= 3'b000;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      tmr_q       <= 16'd0;
      mem_done    <= 1'b0;
      mem_rdata   <= 32'h0;
      mem_fault   <= 1'b0;
      fault_cause <= FC_NONE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= 4'b0000;
      bus_addr    <= '0;
      bus_wdata   <= 32'h0;
    end else begin
      mem_done    <= 1'b0;
      mem_fault   <= 1'b0;
      fault_cause <= FC_NONE;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dmtype_q <= DMType;
            off_q    <= mem_addr[1:0];
            we_q     <= MemWrite;
            if (!dm_legal(DMType)) begin
              state_q     <= ST_FAULT;
              mem_fault   <= 1'b1;
              fault_cause <= FC_ILLEGAL;
            end else if (dm_misaligned(DMType, mem_addr[1:0])) begin
              state_q     <= ST_FAULT;
              mem_fault   <= 1'b1;
              fault_cause <= FC_MISALIGN;
            end else begin
              state_q   <= ST_REQ;
              tmr_q     <= TMR_LOAD;
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_be    <= MemWrite ? st_be : 4'b1111;
              bus_wdata <= MemWrite ? st_data : 32'h0;
              bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_REQ: begin
          // A grant on the terminal-count cycle still wins over the timeout.
          if (bus_gnt) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (we_q) begin
              state_q  <= ST_DONE;
              mem_done <= 1'b1;
            end else begin
              state_q <= ST_WAIT_R;
              tmr_q   <= TMR_LOAD;
            end
          end else if (tmr_tc) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            state_q     <= ST_FAULT;
            mem_fault   <= 1'b1;
            fault_cause <= FC_TIMEOUT;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        ST_WAIT_R: begin
          if (bus_rvalid) begin
            mem_rdata <= ld_data;
            state_q   <= ST_DONE;
            mem_done  <= 1'b1;
          end else if (tmr_tc) begin
            state_q     <= ST_FAULT;
            mem_fault   <= 1'b1;
            fault_cause <= FC_TIMEOUT;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized
// loads/stores against a byte-addressed memory model and a latency model.
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_valid = 1'b0, MemWrite = 1'b0, MemRead = 1'b0;
  logic [2:0]  DMType = 3'b000;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic        mem_stall, mem_done, mem_fault;
  logic [31:0] mem_rdata;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [int unsigned];

  // observations from the last transaction
  int          o_done_cyc, o_fault_cyc, o_req_cyc;
  logic [1:0]  o_cause;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we, o_stall_start, o_stall_bad, o_unstable, o_pulse_bad, o_timeout;

  // model expectations
  int          e_done, e_fault, e_req;
  logic [1:0]  e_cause;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMType(DMType), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_fault(mem_fault), .fault_cause(fault_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  function automatic logic [31:0] mem_rd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Expected outcome from access size, alignment and handshake delays.
  task automatic model(input bit wr, input logic [2:0] dm, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gw, input int rw);
    int size, off;
    logic [31:0] mask, v;
    e_req = 0; e_done = -1; e_fault = -1; e_cause = 2'b00; e_rdata = 32'h0;
    e_be = 4'hF; e_wdata = wdata; e_addr = addr & ~32'd3;
    off  = int'(addr[1:0]);
    size = (dm == 3'd0) ? 4 : (dm <= 3'd2) ? 2 : 1;
    if (dm > 3'd4) begin
      e_fault = 1; e_cause = 2'b11;
    end else if (off % size != 0) begin
      e_fault = 1; e_cause = 2'b01;
    end else begin
      e_be    = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
      e_wdata = (size == 4) ? wdata : (size == 2) ? (wdata & 32'hFFFF) * 32'h00010001
                                                  : (wdata & 32'hFF) * 32'h01010101;
      if (gw >= TO) begin
        e_req = TO; e_fault = TO + 1; e_cause = 2'b10;
      end else begin
        e_req = gw + 1;
        if (wr) e_done = gw + 2;
        else if (rw >= TO) begin
          e_fault = gw + 2 + TO; e_cause = 2'b10;
        end else begin
          e_done = gw + 3 + rw;
          mask = (size == 4) ? 32'hFFFFFFFF : 32'((64'd1 << (8 * size)) - 64'd1);
          v = (mem_rd(addr >> 2) >> (8 * off)) & mask;
          if ((dm == 3'd1 || dm == 3'd3) && v[8 * size - 1]) v = v | ~mask;
          e_rdata = v;
        end
      end
    end
  endtask

  // Issue one access and act as the bus/memory; records observations only.
  task automatic run_txn(input bit wr, input bit rd, input logic [2:0] dm, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gw, input int rw);
    int cyc, gnt_idx;
    bit granted, fin;
    logic [31:0] w;
    o_done_cyc = -1; o_fault_cyc = -1; o_req_cyc = 0; o_cause = 2'b00; o_rdata = 32'h0;
    o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
    o_stall_bad = 1'b0; o_unstable = 1'b0; o_pulse_bad = 1'b0; o_timeout = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; MemWrite = wr; MemRead = rd; DMType = dm; mem_addr = addr; mem_wdata = wdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1 o_stall_start = mem_stall;
    granted = 1'b0; gnt_idx = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      mem_valid = 1'b0; MemWrite = 1'($urandom); MemRead = 1'($urandom);
      DMType = 3'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (mem_done || mem_fault) begin
        o_done_cyc  = mem_done ? cyc : -1;
        o_fault_cyc = mem_fault ? cyc : -1;
        o_cause = fault_cause; o_rdata = mem_rdata;
        if (mem_stall !== 1'b0) o_stall_bad = 1'b1;
        fin = 1'b1;
      end else begin
        if (mem_stall !== 1'b1) o_stall_bad = 1'b1;
        if (bus_req) begin
          o_req_cyc++;
          if (o_req_cyc == 1) begin
            o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
          end else if (bus_addr !== o_addr || bus_be !== o_be || bus_we !== o_we || bus_wdata !== o_wdata)
            o_unstable = 1'b1;
          if (o_req_cyc - 1 == gw) begin
            bus_gnt = 1'b1; granted = 1'b1; gnt_idx = cyc;
            if (bus_we) begin
              w = mem_rd(bus_addr >> 2);
              for (int i = 0; i < 4; i++) if (bus_be[i]) w[8*i +: 8] = bus_wdata[8*i +: 8];
              mem[bus_addr >> 2] = w;
            end
          end else begin
            bus_rvalid = 1'($urandom); bus_rdata = $urandom;
          end
        end else if (granted && !o_we) begin
          if (cyc == gnt_idx + 1 + rw) begin
            bus_rvalid = 1'b1; bus_rdata = mem_rd(o_addr >> 2);
          end else bus_rdata = $urandom;
        end
        if (cyc > 60) begin o_timeout = 1'b1; fin = 1'b1; end
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    if (mem_done || mem_fault || mem_stall) o_pulse_bad = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; mem_valid = 1'b1; MemRead = 1'b1; DMType = 3'b000; mem_addr = 32'h1234;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", mem_done); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", mem_fault); end
    checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL rst_cause got %b exp 00", fault_cause); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", mem_rdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus_we); end
    checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rst_be got %b exp 0000", bus_be); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus_wdata); end
    mem_valid = 1'b0; MemRead = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", mem_stall); end
  endtask

  task automatic test_store_byte;
    run_txn(1'b1, 1'b0, 3'b011, 32'h1003, 32'h000000A5, 2, 0);
    checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", o_addr); end
    checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", o_be); end
    checks++; if (o_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", o_we); end
    checks++; if (o_req_cyc != 3) begin errors++; $display("FAIL sb_req_cycles got %0d exp 3", o_req_cyc); end
    checks++; if (o_done_cyc != 4) begin errors++; $display("FAIL sb_done_cycle got %0d exp 4", o_done_cyc); end
    checks++; if ({o_stall_start, o_stall_bad, o_unstable} !== 3'b100)
      begin errors++; $display("FAIL sb_stall_start_bad_unstable got %b exp 100", {o_stall_start, o_stall_bad, o_unstable}); end
  endtask

  task automatic test_load_half;
    mem[32'h2000 >> 2] = 32'h80011234;
    run_txn(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0, 0, 0);
    checks++; if (o_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed got %h exp ffff8001", o_rdata); end
    checks++; if (o_done_cyc != 3) begin errors++; $display("FAIL lh_done_cycle got %0d exp 3", o_done_cyc); end
    checks++; if ({o_we, o_be} !== 5'b01111) begin errors++; $display("FAIL lh_we_be got %b exp 01111", {o_we, o_be}); end
    run_txn(1'b0, 1'b1, 3'b010, 32'h2002, 32'h0, 1, 1);
    checks++; if (o_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_unsigned got %h exp 00008001", o_rdata); end
  endtask

  task automatic test_faults;
    run_txn(1'b0, 1'b1, 3'b000, 32'h3001, 32'h0, 0, 0);
    checks++; if (o_fault_cyc != 1 || o_cause !== 2'b01)
      begin errors++; $display("FAIL misalign got cyc %0d cause %b exp cyc 1 cause 01", o_fault_cyc, o_cause); end
    checks++; if (o_req_cyc != 0) begin errors++; $display("FAIL misalign_req got %0d exp 0", o_req_cyc); end
    checks++; if (o_stall_start !== 1'b1 || o_pulse_bad) begin errors++; $display("FAIL misalign_stall_pulse got %b%b exp 10", o_stall_start, o_pulse_bad); end
    run_txn(1'b1, 1'b0, 3'b110, 32'h3001, 32'h0, 0, 0);
    checks++; if (o_fault_cyc != 1 || o_cause !== 2'b11)
      begin errors++; $display("FAIL illegal got cyc %0d cause %b exp cyc 1 cause 11", o_fault_cyc, o_cause); end
  endtask

  task automatic test_timeout;
    run_txn(1'b1, 1'b0, 3'b000, 32'h3000, 32'h11223344, 99, 0);
    checks++; if (o_req_cyc != TO) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", o_req_cyc, TO); end
    checks++; if (o_fault_cyc != TO + 1 || o_cause !== 2'b10)
      begin errors++; $display("FAIL to_fault got cyc %0d cause %b exp cyc %0d cause 10", o_fault_cyc, o_cause, TO + 1); end
    run_txn(1'b1, 1'b0, 3'b000, 32'h3000, 32'h11223344, TO - 1, 0);
    checks++; if (o_fault_cyc != -1 || o_done_cyc != TO + 1)
      begin errors++; $display("FAIL to_gnt_at_tc got fault %0d done %0d exp fault -1 done %0d", o_fault_cyc, o_done_cyc, TO + 1); end
    run_txn(1'b0, 1'b1, 3'b000, 32'h3000, 32'h0, 0, 99);
    checks++; if (o_fault_cyc != 2 + TO || o_cause !== 2'b10)
      begin errors++; $display("FAIL to_rvalid got cyc %0d cause %b exp cyc %0d cause 10", o_fault_cyc, o_cause, 2 + TO); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; DMType = 3'b000; mem_addr = 32'h4100;
    @(negedge clk); mem_valid = 1'b0;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_req_before got %b exp 1", bus_req); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0)
      begin errors++; $display("FAIL rm_req_async got req %b stall %b exp 0 0", bus_req, mem_stall); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; MemRead = 1'b1; mem_addr = 32'h4100;
    @(negedge clk); mem_valid = 1'b0; bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rm_wait_stall got %b exp 1", mem_stall); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0)
      begin errors++; $display("FAIL rm_wait_async got req %b stall %b exp 0 0", bus_req, mem_stall); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_done || mem_fault) seen++;
      if (i == 1) rstn = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = $urandom;
    end
    bus_rvalid = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL rm_no_pulse got %0d pulses exp 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    d = $urandom;
    run_txn(1'b1, 1'b0, 3'b000, 32'h4000, d, 0, 0);
    checks++; if (o_done_cyc != 2) begin errors++; $display("FAIL b2b_store_done got %0d exp 2", o_done_cyc); end
    run_txn(1'b0, 1'b1, 3'b000, 32'h4000, 32'h0, 0, 0);
    checks++; if (o_done_cyc != 3 || o_rdata !== d)
      begin errors++; $display("FAIL b2b_load got cyc %0d data %h exp cyc 3 data %h", o_done_cyc, o_rdata, d); end
  endtask

  task automatic test_random;
    bit wr, rd;
    logic [2:0] dm;
    logic [31:0] addr, wd;
    int gw, rw;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); rd = !wr | 1'($urandom);
      dm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = 32'h5000 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom;
      gw = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, TO - 1);
      rw = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, TO - 1);
      model(wr, dm, addr, wd, gw, rw);
      run_txn(wr, rd, dm, addr, wd, gw, rw);
      checks++; if (o_timeout || o_done_cyc != e_done || o_fault_cyc != e_fault)
        begin errors++; $display("FAIL rnd%0d_outcome got done %0d fault %0d exp done %0d fault %0d", n, o_done_cyc, o_fault_cyc, e_done, e_fault); end
      checks++; if (o_cause !== e_cause) begin errors++; $display("FAIL rnd%0d_cause got %b exp %b", n, o_cause, e_cause); end
      checks++; if (o_req_cyc != e_req) begin errors++; $display("FAIL rnd%0d_req_cycles got %0d exp %0d", n, o_req_cyc, e_req); end
      checks++; if ({o_stall_start, o_stall_bad, o_unstable, o_pulse_bad} !== 4'b1000)
        begin errors++; $display("FAIL rnd%0d_stall_stable_pulse got %b exp 1000", n, {o_stall_start, o_stall_bad, o_unstable, o_pulse_bad}); end
      if (e_req > 0) begin
        checks++; if (o_addr !== e_addr || o_be !== e_be || o_we !== wr)
          begin errors++; $display("FAIL rnd%0d_bus got %h %b %b exp %h %b %b", n, o_addr, o_be, o_we, e_addr, e_be, wr); end
        if (wr) begin
          checks++; if (o_wdata !== e_wdata) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, o_wdata, e_wdata); end
        end else if (e_done > 0) begin
          checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, o_rdata, e_rdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
